rd_ptr_ctrl: RTL and testbench
==============================

Name: rd_ptr_ctrl

Overview:
Parametrised read-side control for the asynchronous FIFO. It is the next generation of the existing read logic. It keeps a binary/Gray read pointer pair and a registered empty flag in the rd_clk domain. New over the previous generation:
- depth set by parameter
- registered fill level
- programmable almost-empty flag
- sticky underflow error
- optional in-block write-pointer synchronizer

It drives the read address of the dual-port RAM and returns its Gray pointer to the write domain.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH; legal range 0..DEPTH
SYNC_STAGES, 2, synchronizer flop count (min 2); used only when RD_PTR_CTRL_SYNC_EN is defined

Ports:
rd_clk  input  1  read-domain clock
rd_rst  input  1  asynchronous active-high reset
rd_en  input  1  read request
underflow_clr  input  1  clears sticky underflow
wptr_gray_in  input  ADDR_WIDTH+1  write pointer, Gray (raw or pre-synchronized, see Optional Feature)
rd_addr  output  ADDR_WIDTH  RAM read address, = rbin[ADDR_WIDTH-1:0]
rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer to write domain
rd_ack  output  1  combinational: rd_en & ~empty; read accepted this cycle
empty  output  1  registered empty flag
almost_empty  output  1  registered, level <= AE_THRESH
rd_level  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset is asynchronous and active-high (rd_rst), clocked by rd_clk.
- Reset values: rbin=0, rd_ptr_gray=0, rd_addr=0, empty=1, almost_empty=1, rd_level=0, underflow=0. Synchronizer flops (if present) also reset to 0.
- Reset applied mid-operation takes effect immediately, with no clock needed. A read in progress is abandoned.
- wq = synchronized write pointer (see Optional Feature).
- rbin_next = rbin + rd_ack, modulo 2**(ADDR_WIDTH+1). The MSB toggles per lap.
- rgray_next = rbin_next ^ (rbin_next >> 1). On every rd_clk edge: rbin <= rbin_next and rd_ptr_gray <= rgray_next.
- empty <= (rgray_next == wq).
- wbin = gray-to-binary(wq), combinational XOR prefix from the MSB.
- rd_level <= (wbin - rbin_next) modulo 2**(ADDR_WIDTH+1). Result never exceeds DEPTH for legal write-side behaviour.
- almost_empty <= (level_next <= AE_THRESH), where level_next is the value being loaded into rd_level.
- Read latency:
  - rd_addr is valid in the same cycle as rd_ack.
  - The RAM read is the RAM's own concern.
  - The pointer advances at the edge that ends the rd_ack cycle.
- Read while empty: rd_ack=0 and pointers hold; underflow <= 1 at that edge.
- underflow_clr clears underflow at the next edge. If set and clear occur in the same cycle, set wins.
- Writes becoming visible while a read occurs in the same cycle: the level reflects both (new wbin minus rbin_next). empty clears only through a wq change.
- Pessimism: empty and almost_empty may lag real availability by sync latency + 1 cycle. They never report data that is absent.
- Wrap: rbin rolls over from 2**(ADDR_WIDTH+1)-1 to 0, and rd_addr rolls over from DEPTH-1 to 0. Level and empty remain correct across the boundary.
- AE_THRESH >= DEPTH: almost_empty is constantly 1 after reset. The simulation-only parameter check must flag AE_THRESH > DEPTH.

Optional Feature:
Macro RD_PTR_CTRL_SYNC_EN.
- Defined: wptr_gray_in is treated as raw from the write domain. It passes through a SYNC_STAGES-deep flop chain on rd_clk, reset by rd_rst, and wq is the last stage. Flag and level latency from write-pointer change is SYNC_STAGES+1 cycles.
- Undefined: wptr_gray_in is already synchronized externally and wq = wptr_gray_in directly, giving latency of 1 cycle. SYNC_STAGES is ignored.

Test Plan:
Values below use ADDR_WIDTH=4, AE_THRESH=2, SYNC_STAGES=2, with the macro defined unless stated.
1. Reset: pulse rd_rst between clock edges -> immediately empty=1, almost_empty=1, rd_level=0, rd_ptr_gray=5'b00000, rd_addr=0, underflow=0.
2. Fill visibility: wptr_gray_in from 0 to 5'b00111 (binary 5) -> 3 edges later empty=0, rd_level=5, almost_empty=0. With the macro undefined, the same response appears after 1 edge.
3. Drain: with the write pointer at binary 5, rd_en=1 for 3 cycles -> rd_addr 0,1,2 with rd_ack=1 each cycle; rd_level 4,3,2; almost_empty=1 after the third edge; rd_ptr_gray=5'b00010.
4. Underflow: empty=1 and rd_en=1 for 1 cycle -> rd_ack=0, rd_addr unchanged, underflow=1 and held. underflow_clr and rd_en-on-empty asserted together -> stays 1. underflow_clr alone -> 0.
5. Wrap: advance the write pointer and read continuously for 40 entries -> rbin goes 31 to 0, rd_ptr_gray goes 5'b10000 to 5'b00000, rd_addr goes 15 to 0. empty/level match the reference model every cycle. rd_level reaches 16 when the write pointer is one full lap ahead.
6. Mid-op reset: with rd_level=7, assert rd_rst for 1 cycle -> all outputs take reset values asynchronously. After release with the write pointer unchanged, rd_level returns to the write-pointer value after 3 edges.

Source files
------------

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer/flag control for the asynchronous FIFO: binary/Gray read pointer, empty, level, almost-empty, underflow.
// Optional macro RD_PTR_CTRL_SYNC_EN adds an in-block SYNC_STAGES-deep write-pointer synchronizer.
module rd_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AE_THRESH   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic                  underflow_clr,
  input  logic [ADDR_WIDTH:0]   wptr_gray_in,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  rd_ack,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Elaboration-time parameter sanity checks
  if (AE_THRESH > DEPTH) begin : g_bad_ae_thresh
    $error("rd_ptr_ctrl: AE_THRESH (%0d) exceeds DEPTH (%0d)", AE_THRESH, DEPTH);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("rd_ptr_ctrl: SYNC_STAGES (%0d) must be at least 2", SYNC_STAGES);
  end

  logic [PW-1:0] wq;
  logic [PW-1:0] wbin;

`ifdef RD_PTR_CTRL_SYNC_EN
  logic [PW-1:0] sync_q [SYNC_STAGES];

  // Write pointer crosses into rd_clk through a plain flop chain
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq = sync_q[SYNC_STAGES-1];
`else
  assign wq = wptr_gray_in;
`endif

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic          uf_q, uf_d;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    wbin = '0;
    for (int unsigned i = 0; i < PW; i++) wbin[i] = ^(wq >> i);
  end

  assign rd_ack = rd_en & ~empty_q;

  always_comb begin
    rbin_d  = rbin_q + PW'(rd_ack);
    rgray_d = rbin_d ^ (rbin_d >> 1);
    empty_d = (rgray_d == wq);
    level_d = wbin - rbin_d;
    ae_d    = (32'(level_d) <= AE_THRESH);
    uf_d    = uf_q;
    if (rd_en && empty_q) begin
      uf_d = 1'b1;
    end else if (underflow_clr) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
    end
  end

  assign rd_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray  = rgray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed + randomized bench for rd_ptr_ctrl against a read/write-count model of the FIFO.
module tb_rd_ptr_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned AE    = 2;
  localparam int unsigned SS    = 2;
  localparam int          DEPTH = 16;
`ifdef RD_PTR_CTRL_SYNC_EN
  localparam int DLY = SS;
`else
  localparam int DLY = 0;
`endif

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          rd_en;
  logic          underflow_clr;
  logic [AW:0]   wptr_gray_in;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr_gray;
  logic          rd_ack;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_level;
  logic          underflow;

  rd_ptr_ctrl #(.ADDR_WIDTH(AW), .AE_THRESH(AE), .SYNC_STAGES(SS)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .underflow_clr(underflow_clr),
    .wptr_gray_in(wptr_gray_in), .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray),
    .rd_ack(rd_ack), .empty(empty), .almost_empty(almost_empty),
    .rd_level(rd_level), .underflow(underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int ncmp = 0;
  int nfail = 0;

  // Model: total entries written (w) and read (r); write count seen by the reader lags by DLY edges
  int w = 0;
  int r = 0;
  int hist [DLY+1];
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_ae = 1'b1;
  bit m_uf = 1'b0;

  function automatic logic [4:0] gray_of(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("empty", 32'(empty), 32'(m_empty));
    chk("almost_empty", 32'(almost_empty), 32'(m_ae));
    chk("rd_level", 32'(rd_level), 32'(m_level));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("rd_addr", 32'(rd_addr), 32'(r % DEPTH));
    chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray_of(r)));
  endtask

  task automatic model_reset();
    r = 0;
    for (int i = 0; i <= DLY; i++) hist[i] = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_ae = 1'b1;
    m_uf = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, advance model, check registered outputs
  task automatic step(input bit en, input bit clr, input int wnew);
    bit ack;
    rd_en = en;
    underflow_clr = clr;
    w = wnew;
    wptr_gray_in = gray_of(w);
    #1;
    ack = en && !m_empty;
    chk("rd_ack", 32'(rd_ack), 32'(ack));
    chk("rd_addr_pre", 32'(rd_addr), 32'(r % DEPTH));
    @(posedge rd_clk);
    if (!rd_rst) begin
      if (en && m_empty) m_uf = 1'b1;
      else if (clr) m_uf = 1'b0;
      r += int'(ack);
      for (int i = DLY; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = w;
      m_level = hist[DLY] - r;
      m_empty = (m_level == 0);
      m_ae = (m_level <= int'(AE));
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset held across one edge, checked before and after that edge
  task automatic do_reset();
    #3;
    rd_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge rd_clk);
    #1;
    check_all();
    #2;
    rd_rst = 1'b0;
  endtask

  initial begin
    rd_rst = 1'b1;
    rd_en = 1'b0;
    underflow_clr = 1'b0;
    wptr_gray_in = '0;
    model_reset();
    #1;
    check_all();
    @(posedge rd_clk);
    #2;
    rd_rst = 1'b0;
    @(posedge rd_clk);
    #1;

    // Reset pulse between edges
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(rd_level), 32'd0);

    // Fill visibility: write pointer jumps to 5
    step(1'b0, 1'b0, 5);
    for (int i = 0; i < DLY; i++) step(1'b0, 1'b0, 5);
    chk("fill_level", 32'(rd_level), 32'd5);
    chk("fill_empty", 32'(empty), 32'd0);
    chk("fill_ae", 32'(almost_empty), 32'd0);

    // Drain three entries
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5);
    chk("drain_level", 32'(rd_level), 32'd2);
    chk("drain_ae", 32'(almost_empty), 32'd1);
    chk("drain_gray", 32'(rd_ptr_gray), 32'h02);

    // Empty out, then underflow set / set-beats-clear / clear
    step(1'b1, 1'b0, 5);
    step(1'b1, 1'b0, 5);
    chk("empty_after_drain", 32'(empty), 32'd1);
    step(1'b1, 1'b0, 5);
    chk("uf_set", 32'(underflow), 32'd1);
    chk("uf_addr_hold", 32'(rd_addr), 32'd5);
    step(1'b0, 1'b0, 5);
    chk("uf_hold", 32'(underflow), 32'd1);
    step(1'b1, 1'b1, 5);
    chk("uf_set_wins", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 5);
    chk("uf_clr", 32'(underflow), 32'd0);

    // Mid-operation reset with level 7
    step(1'b0, 1'b0, 12);
    for (int i = 0; i < DLY; i++) step(1'b0, 1'b0, 12);
    chk("pre_rst_level", 32'(rd_level), 32'd7);
    do_reset();
    for (int i = 0; i <= DLY; i++) step(1'b0, 1'b0, 12);
    chk("post_rst_level", 32'(rd_level), 32'd12);

    // Fill to a full lap ahead
    while (w - r < DEPTH) step(1'b0, 1'b0, w + 1);
    for (int i = 0; i < DLY; i++) step(1'b0, 1'b0, w);
    chk("full_level", 32'(rd_level), 32'd16);

    // Continuous read across the pointer wrap while writes keep coming
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, (w - r < DEPTH) ? w + 1 : w);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit en;
      bit clr;
      int wn;
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      wn = w;
      if ((w - r < DEPTH) && ($urandom_range(0, 2) != 0)) wn = w + 1;
      step(en, clr, wn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
